// File: rtl/tdm_pkg.sv
// Shared constants for the TDM link: the frame geometry and the receiver
// framing-state encoding. The TDM transmitter imports the same package.
package tdm_pkg;

    localparam int SLOTS  = 4;
    localparam int SLOT_W = 2;

    localparam logic [SLOT_W-1:0] SLOT_ZERO = 2'd0;
    localparam logic [SLOT_W-1:0] SLOT_ONE  = 2'd1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = 2'd3;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_e;

endpackage : tdm_pkg

// File: rtl/tdm_demux_4ch_if.sv
// Serial TDM input stream and 4-slot parallel frame output of the demux.
// The slave modport is the demux itself; the master modport is its environment.
interface tdm_demux_4ch_if #(parameter int WIDTH = 1);

    logic                              din_valid;
    logic [WIDTH-1:0]                  din;
    logic                              frame_sync;
    logic [tdm_pkg::SLOTS*WIDTH-1:0]   data_out;
    logic                              frame_valid;
    logic                              sync_err;
    logic                              locked;

    modport master (
        output din_valid, din, frame_sync,
        input  data_out, frame_valid, sync_err, locked
    );

    modport slave (
        input  din_valid, din, frame_sync,
        output data_out, frame_valid, sync_err, locked
    );

endinterface : tdm_demux_4ch_if

// File: rtl/tdm_slot_ctr.sv
// Slot index counter for the TDM receiver: loads 1 on a sync sample,
// increments on enable and wraps 3 -> 0; wrap flags the last slot.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    output logic [SLOT_W-1:0] cnt,
    output logic              wrap
);

    logic [SLOT_W-1:0] cnt_r;

    // Slot counter register; load takes priority over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= SLOT_ZERO;
        end else if (load) begin
            cnt_r <= SLOT_ONE;
        end else if (en) begin
            cnt_r <= cnt_r + SLOT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt  = cnt_r;
    assign wrap = (cnt_r == SLOT_LAST);

endmodule : tdm_slot_ctr

// File: rtl/tdm_demux_4ch.sv
// Four-channel TDM demultiplexer: stages slots 0..2, then publishes the whole
// frame on data_out together with slot 3 so consumers never see a partial frame.
module tdm_demux_4ch
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
)
(
    input  logic          clk,
    input  logic          rst,
    tdm_demux_4ch_if.slave bus
);

    tdm_state_e                  state_r;
    logic [SLOT_W-1:0]           cnt_s;
    logic                        wrap_s;
    logic                        ctr_load_s;
    logic                        ctr_en_s;
    logic [2:0][WIDTH-1:0]       stg_r;
    logic [SLOTS*WIDTH-1:0]      data_out_r;
    logic                        frame_valid_r;
    logic                        sync_err_r;
    logic                        locked_r;

    // A missing sync leaves the counter at 0, so it only advances on mid-frame slots.
    assign ctr_load_s = bus.din_valid & bus.frame_sync;
    assign ctr_en_s   = bus.din_valid & ~bus.frame_sync &
                        (state_r == LOCKED) & (cnt_s != SLOT_ZERO);

    tdm_slot_ctr u_slot_ctr (
        .clk  (clk),
        .rst  (rst),
        .en   (ctr_en_s),
        .load (ctr_load_s),
        .cnt  (cnt_s),
        .wrap (wrap_s)
    );

    // Framing FSM with staging register and registered frame/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= HUNT;
            stg_r         <= '0;
            data_out_r    <= '0;
            frame_valid_r <= 1'b0;
            sync_err_r    <= 1'b0;
            locked_r      <= 1'b0;
        end else begin
            frame_valid_r <= 1'b0;
            sync_err_r    <= 1'b0;
            if (bus.din_valid) begin
                case (state_r)
                    HUNT: begin
                        if (bus.frame_sync) begin
                            stg_r[0] <= bus.din;
                            state_r  <= LOCKED;
                            locked_r <= 1'b1;
                        end else begin
                            state_r  <= HUNT;
                        end
                    end
                    LOCKED: begin
                        if (bus.frame_sync) begin
                            // Early sync restarts the frame; stale slots get overwritten.
                            stg_r[0]   <= bus.din;
                            sync_err_r <= (cnt_s != SLOT_ZERO);
                        end else if (cnt_s == SLOT_ZERO) begin
                            sync_err_r <= 1'b1;
                            state_r    <= HUNT;
                            locked_r   <= 1'b0;
                        end else if (wrap_s) begin
                            data_out_r    <= {bus.din, stg_r[2], stg_r[1], stg_r[0]};
                            frame_valid_r <= 1'b1;
                        end else if (cnt_s == SLOT_ONE) begin
                            stg_r[1] <= bus.din;
                        end else begin
                            stg_r[2] <= bus.din;
                        end
                    end
                    default: begin
                        state_r  <= HUNT;
                        locked_r <= 1'b0;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign bus.data_out    = data_out_r;
    assign bus.frame_valid = frame_valid_r;
    assign bus.sync_err    = sync_err_r;
    assign bus.locked      = locked_r;

endmodule : tdm_demux_4ch
